// File: rtl/destuff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : destuff_pkg
// Purpose  : Shared defaults, abort-run length and saturating increment for
//            the bit de-stuffing datapath.
// Revision : 1.0 - initial release
// ============================================================================
package destuff_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  // Consecutive accepted ones that signal an abort (only used when the
  // ABORT_DETECT_EN macro is defined).
  localparam int ABORT_RUN  = 7;
  localparam int RUN_W      = $clog2(ABORT_RUN + 1);

  // Increment val, holding at the all-ones value of a width-bit counter.
  // Counters up to 32 bits wide are supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? val : val + 32'd1;
  endfunction

endpackage : destuff_pkg
`default_nettype wire

// File: rtl/bit_destuffer_hold_buf.sv
`default_nettype none
// ============================================================================
// Module   : byte_hold_buf
// Purpose  : One-entry valid/ready output register. A load is taken when the
//            entry is empty or is being drained in the same cycle; otherwise
//            the incoming word is dropped and ovr_pulse is raised.
// Revision : 1.0 - initial release
// ============================================================================
module byte_hold_buf
  import destuff_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              ovr_pulse
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;

  // Next-state: load (with pass-through on drain), consume, or drop on full.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    ovr_pulse = 1'b0;
    if (load) begin
      if (!valid_q || out_ready) begin
        valid_d = 1'b1;
        data_d  = data_in;
      end else begin
        ovr_pulse = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Entry register; data keeps its last value after the word is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule : byte_hold_buf
`default_nettype wire

// File: rtl/bit_destuffer.sv
`default_nettype none
// ============================================================================
// Module   : bit_destuffer
// Purpose  : Removes detector-flagged stuffed zeros from a serial line and
//            assembles the remaining bits LSB-first into DATA_W-bit words,
//            presented through a one-entry valid/ready buffer. Counts removed
//            bits and flags lost words.
// Options  : ABORT_DETECT_EN - abort a partial word on a run of ABORT_RUN
//            accepted ones and pulse the abort output.
// Revision : 1.0 - initial release
// ============================================================================
module bit_destuffer
  import destuff_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i,
  input  logic              w,
  input  logic              clr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stuff_cnt,
  output logic              overrun,
  output logic              abort
);

  localparam int                 BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  logic                 bit_d_q,     bit_d_d;
  logic                 bit_d_vld_q, bit_d_vld_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [DATA_W-1:0]    shreg_q,     shreg_d;
  logic [CNT_W-1:0]     stuff_cnt_q, stuff_cnt_d;
  logic                 overrun_q,   overrun_d;

  logic                 word_load;
  logic [DATA_W-1:0]    word_data;
  logic                 ovr_pulse;
  logic                 abort_hit;

`ifdef ABORT_DETECT_EN
  logic [RUN_W-1:0]     run_q,   run_d;
  logic                 abort_q, abort_d;
  logic [RUN_W-1:0]     run_next;
`endif

  // Accept rule: drop flagged bits, otherwise shift the delayed bit into the
  // word and hand a completed word to the output buffer.
  always_comb begin
    bit_d_d     = i;
    bit_d_vld_d = 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    stuff_cnt_d = stuff_cnt_q;
    word_load   = 1'b0;
    word_data   = shreg_q;
    abort_hit   = 1'b0;
`ifdef ABORT_DETECT_EN
    run_d       = run_q;
    abort_d     = 1'b0;
    run_next    = '0;
`endif
    if (clr) begin
      bit_cnt_d   = '0;
      shreg_d     = '0;
      stuff_cnt_d = '0;
`ifdef ABORT_DETECT_EN
      run_d       = '0;
`endif
    end else if (bit_d_vld_q) begin
      if (w) begin
        stuff_cnt_d = CNT_W'(sat_inc(32'(stuff_cnt_q), CNT_W));
      end else begin
`ifdef ABORT_DETECT_EN
        run_next = bit_d_q ? run_q + RUN_W'(1) : '0;
        if (run_next == RUN_W'(ABORT_RUN)) begin
          abort_hit = 1'b1;
          abort_d   = 1'b1;
          run_d     = '0;
        end else begin
          run_d     = run_next;
        end
`endif
        word_data[bit_cnt_q] = bit_d_q;
        if (abort_hit) begin
          bit_cnt_d = '0;
          shreg_d   = '0;
        end else if (bit_cnt_q == LAST_BIT) begin
          word_load = 1'b1;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end else begin
          shreg_d   = word_data;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end
    end
  end

  // Sticky overrun: set by a dropped word, cleared only by clr.
  always_comb begin
    overrun_d = clr ? 1'b0 : (overrun_q | ovr_pulse);
  end

  // Alignment register, word assembly state and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_d_q     <= 1'b0;
      bit_d_vld_q <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      stuff_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      bit_d_q     <= bit_d_d;
      bit_d_vld_q <= bit_d_vld_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      stuff_cnt_q <= stuff_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef ABORT_DETECT_EN
  // Run-of-ones tracker and registered abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      abort_q <= abort_d;
    end
  end

  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

  byte_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (word_load),
    .data_in   (word_data),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .ovr_pulse (ovr_pulse)
  );

  assign stuff_cnt = stuff_cnt_q;
  assign overrun   = overrun_q;

endmodule : bit_destuffer
`default_nettype wire
